// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mem_arbiter_pkg : state encoding, port ids and bus widths shared with caches
// Revision: 1.0
// ============================================================================
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 6;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GRANT_I = 2'b01,
    ST_GRANT_D = 2'b10
  } arb_state_e;

  localparam logic c_port_i = 1'b0;
  localparam logic c_port_d = 1'b1;

  function automatic logic rr_pick(input logic last); return ~last; endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : round-robin arbiter giving I-cache and D-cache one shared memory
// Revision: 1.0
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       issued_q, issued_d;
  logic       w_i_req, w_d_req;
  logic       w_i_done, w_d_done;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;

  // The first grant cycle never completes: memory has not yet seen the command.
  assign w_i_done = (state_q == ST_GRANT_I) && issued_q && !mem_busywait;
  assign w_d_done = (state_q == ST_GRANT_D) && issued_q && !mem_busywait;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    issued_d = issued_q;
    unique case (state_q)
      ST_IDLE: begin
        issued_d = 1'b0;
        if (w_i_req && w_d_req) begin
          state_d = (rr_pick(last_q) == c_port_i) ? ST_GRANT_I : ST_GRANT_D;
        end else if (w_i_req) begin
          state_d = ST_GRANT_I;
        end else if (w_d_req) begin
          state_d = ST_GRANT_D;
        end
      end
      ST_GRANT_I: begin
        if (!w_i_req) begin
          state_d  = ST_IDLE;
          issued_d = 1'b0;
        end else if (w_i_done) begin
          state_d  = ST_IDLE;
          issued_d = 1'b0;
          last_d   = c_port_i;
        end else begin
          issued_d = 1'b1;
        end
      end
      ST_GRANT_D: begin
        if (!w_d_req) begin
          state_d  = ST_IDLE;
          issued_d = 1'b0;
        end else if (w_d_done) begin
          state_d  = ST_IDLE;
          issued_d = 1'b0;
          last_d   = c_port_d;
        end else begin
          issued_d = 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        issued_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      last_q   <= c_port_d;
      issued_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      issued_q <= issued_d;
    end
  end

  // A simultaneous read and write from the D side is a write-back.
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    case (state_q)
      ST_GRANT_I: begin
        mem_read    = i_read;
        mem_address = i_address;
      end
      ST_GRANT_D: begin
        mem_read      = d_read & ~d_write;
        mem_write     = d_write;
        mem_address   = d_address;
        mem_writedata = d_writedata;
      end
      default: ;
    endcase
  end

  assign i_busywait = w_i_req & ~w_i_done;
  assign d_busywait = w_d_req & ~w_d_done;
  assign i_readdata = mem_readdata;
  assign d_readdata = mem_readdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : directed and random transfers against a cycle-timed model
// Revision: 1.0
// ============================================================================
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        i_read;
  logic [5:0]  i_address;
  logic [31:0] i_readdata;
  logic        i_busywait;
  logic        d_read;
  logic        d_write;
  logic [5:0]  d_address;
  logic [31:0] d_writedata;
  logic [31:0] d_readdata;
  logic        d_busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mrdata;
  logic        mbusy;

  logic [31:0] mem_q [64];
  logic [31:0] sh    [64];
  int          mcnt;
  logic        mlast;
  int          passed;
  int          total;
  int          fails;
  logic        r_ir, r_dr, r_dw;
  logic [5:0]  r_ia, r_da;
  logic [31:0] r_wd;

  mem_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_readdata   (i_readdata),
    .i_busywait   (i_busywait),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_writedata  (d_writedata),
    .d_readdata   (d_readdata),
    .d_busywait   (d_busywait),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_writedata(mem_writedata),
    .mem_readdata (mrdata),
    .mem_busywait (mbusy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: busy for five cycles after it sees a command, then one idle cycle with data.
  always @(posedge clk) begin
    if (mem_read || mem_write) begin
      if (mcnt < 5) begin
        mcnt  <= mcnt + 1;
        mbusy <= 1'b1;
      end else if (mcnt == 5) begin
        mcnt  <= 6;
        mbusy <= 1'b0;
        if (mem_write) mem_q[mem_address] <= mem_writedata;
        else           mrdata <= mem_q[mem_address];
      end
    end else begin
      mcnt  <= 0;
      mbusy <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One arbitration round: winner completes in cycle 7, loser in cycle 15 (IDLE is cycle 0).
  task automatic contend(input logic ir, input logic dr, input logic dw,
                         input logic [5:0] ia, input logic [5:0] da, input logic [31:0] dwd);
    logic has_i, has_d, first_d, i_act, d_act, own_i, own_d;
    int   i_end, d_end, n;
    has_i   = ir;
    has_d   = dr | dw;
    first_d = has_d && (!has_i || mlast == 1'b0);
    i_end   = has_i ? (first_d ? 15 : 7) : -100;
    d_end   = has_d ? (first_d ? 7 : 15) : -100;
    n       = (has_i && has_d) ? 15 : 7;
    i_act   = has_i;
    d_act   = has_d;
    i_read = ir; i_address = ia;
    d_read = dr; d_write = dw; d_address = da; d_writedata = dwd;
    for (int c = 0; c <= n; c++) begin
      @(negedge clk);
      own_i = has_i && (c >= i_end - 6) && (c <= i_end);
      own_d = has_d && (c >= d_end - 6) && (c <= d_end);
      chk("mem_read", {31'd0, mem_read}, own_i ? 32'd1 : (own_d ? {31'd0, dr & ~dw} : 32'd0));
      chk("mem_write", {31'd0, mem_write}, {31'd0, own_d & dw});
      chk("mem_address", {26'd0, mem_address}, own_i ? {26'd0, ia} : (own_d ? {26'd0, da} : 32'd0));
      if (own_d && dw) chk("mem_writedata", mem_writedata, dwd);
      if (!own_i && !own_d) chk("mem_writedata_idle", mem_writedata, 32'd0);
      chk("i_busywait", {31'd0, i_busywait}, {31'd0, i_act && (c != i_end)});
      chk("d_busywait", {31'd0, d_busywait}, {31'd0, d_act && (c != d_end)});
      if (c == i_end) chk("i_readdata", i_readdata, sh[ia]);
      if (c == d_end && !dw) chk("d_readdata", d_readdata, sh[da]);
      @(posedge clk);
      #1;
      if (c == i_end) begin
        i_read = 1'b0;
        i_act  = 1'b0;
        mlast  = 1'b0;
      end
      if (c == d_end) begin
        d_read  = 1'b0;
        d_write = 1'b0;
        d_act   = 1'b0;
        mlast   = 1'b1;
        if (dw) sh[da] = dwd;
      end
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    mlast = 1'b1;
  endtask

  initial begin
    passed = 0; total = 0; fails = 0; mcnt = 0; mbusy = 1'b0; mrdata = '0;
    reset = 1'b1; i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_writedata = '0;
    for (int k = 0; k < 64; k++) begin
      mem_q[k] = $urandom;
      sh[k]    = mem_q[k];
    end
    apply_reset();

    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("idle_mem_read", {31'd0, mem_read}, 32'd0);
      chk("idle_mem_write", {31'd0, mem_write}, 32'd0);
      chk("idle_mem_address", {26'd0, mem_address}, 32'd0);
      chk("idle_mem_writedata", mem_writedata, 32'd0);
      chk("idle_i_busywait", {31'd0, i_busywait}, 32'd0);
      chk("idle_d_busywait", {31'd0, d_busywait}, 32'd0);
    end
    @(posedge clk);
    #1;

    contend(1'b1, 1'b0, 1'b0, 6'h0A, 6'h00, 32'h0);
    contend(1'b0, 1'b0, 1'b1, 6'h00, 6'h15, 32'hDEADBEEF);
    chk("mem_0x15", mem_q[6'h15], 32'hDEADBEEF);

    apply_reset();
    contend(1'b1, 1'b1, 1'b0, 6'h03, 6'h04, 32'h0);
    contend(1'b1, 1'b1, 1'b0, 6'h05, 6'h06, 32'h0);
    contend(1'b1, 1'b1, 1'b0, 6'h07, 6'h08, 32'h0);

    apply_reset();
    d_write = 1'b1; d_address = 6'h2C; d_writedata = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("pre_reset_mem_write", {31'd0, mem_write}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mlast = 1'b1;
    contend(1'b0, 1'b0, 1'b1, 6'h00, 6'h2C, 32'hCAFEF00D);
    chk("mem_0x2C", mem_q[6'h2C], 32'hCAFEF00D);

    contend(1'b0, 1'b1, 1'b1, 6'h00, 6'h11, 32'h12345678);
    contend(1'b1, 1'b1, 1'b1, 6'h11, 6'h11, 32'hA5A5A5A5);

    for (int k = 0; k < 25; k++) begin
      r_ir = 1'($urandom_range(0, 1));
      r_dr = 1'($urandom_range(0, 1));
      r_dw = 1'($urandom_range(0, 1));
      if (!r_ir && !r_dr && !r_dw) r_ir = 1'b1;
      r_ia = 6'($urandom);
      r_da = ($urandom_range(0, 3) == 0) ? r_ia : 6'($urandom);
      r_wd = $urandom;
      contend(r_ir, r_dr, r_dw, r_ia, r_da, r_wd);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
